// File: rtl/hansen_muldiv_pkg.sv
// Shared encodings for the hansen_muldiv M-extension unit: funct3 op codes, FSM states
// and a small op-class helper.
package hansen_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/hansen_muldiv_special.sv
// Combinational detection of divide-by-zero and signed-overflow divides, with the
// architecturally defined result for each.
module hansen_muldiv_special
  import hansen_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            hit_o,
  output logic [XLEN-1:0] value_o
);

  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  logic b_zero;
  logic ovf;

  always_comb begin
    b_zero  = (b_i == '0);
    ovf     = ((op_i == OP_DIV) || (op_i == OP_REM)) && (a_i == MinVal) && (b_i == '1);
    hit_o   = is_div(op_i) && (b_zero || ovf);
    value_o = '0;
    // op_i[1] separates REM/REMU from DIV/DIVU
    if (b_zero) begin
      value_o = op_i[1] ? a_i : '1;
    end else if (ovf) begin
      value_o = op_i[1] ? '0 : a_i;
    end
  end

endmodule

// File: rtl/hansen_muldiv.sv
// Iterative RV M-extension unit: shift-add multiply and restoring divide, one bit per cycle.
// Define HANSEN_MULDIV_FAST_MUL_EN to compute MUL* with a single-cycle combinational product.
module hansen_muldiv
  import hansen_muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  state_e              state_q;
  logic [2:0]          op_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [XLEN-1:0]     mcand_q;
  logic [2*XLEN-1:0]   acc_q;
  logic                qneg_q;
  logic                rneg_q;
  logic                out_valid_q;
  logic                busy_q;
  logic [XLEN-1:0]     result_q;

  logic                sp_hit;
  logic [XLEN-1:0]     sp_val;

  hansen_muldiv_special #(
    .XLEN(XLEN)
  ) u_special (
    .op_i   (op_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .hit_o  (sp_hit),
    .value_o(sp_val)
  );

  logic                a_neg;
  logic                b_neg;
  logic [XLEN-1:0]     a_mag;
  logic [XLEN-1:0]     b_mag;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       rem_sh;
  logic [XLEN:0]       div_diff;
  logic [2*XLEN-1:0]   div_next;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo;
  logic [XLEN-1:0]     rem;
  logic [XLEN-1:0]     fix_res;

  always_comb begin
    a_neg = a_i[XLEN-1] & ((op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                           (op_i == OP_DIV) || (op_i == OP_REM));
    b_neg = b_i[XLEN-1] & ((op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM));
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;

    // acc = {partial product, remaining multiplier bits}
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // acc = {partial remainder, dividend bits shifting into quotient bits}
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = rem_sh - {1'b0, mcand_q};
    div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    prod = qneg_q ? -acc_q : acc_q;
    quo  = qneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (is_div(op_q)) begin
      fix_res = op_q[1] ? rem : quo;
    end else begin
      fix_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

`ifdef HANSEN_MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a;
  logic signed [XLEN:0]     fast_b;
  logic signed [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]          fast_res;

  always_comb begin
    fast_a    = {a_i[XLEN-1] & ((op_i == OP_MULH) || (op_i == OP_MULHSU)), a_i};
    fast_b    = {b_i[XLEN-1] & (op_i == OP_MULH), b_i};
    fast_prod = fast_a * fast_b;
    fast_res  = (op_i == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else if (kill_i) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            op_q   <= op_i;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (sp_hit) begin
              result_q    <= sp_val;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
`ifdef HANSEN_MULDIV_FAST_MUL_EN
            end else if (!is_div(op_i)) begin
              result_q    <= fast_res;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
`endif
            end else begin
              // Same operand layout serves both multiply and divide
              mcand_q <= b_mag;
              acc_q   <= {{XLEN{1'b0}}, a_mag};
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (cnt_q == CNT_W'(XLEN)) begin
            result_q    <= fix_res;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            acc_q <= is_div(op_q) ? div_next : mul_next;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE) & ~reset_i;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_hansen_muldiv.sv
// Scoreboard bench for hansen_muldiv: driver pushes expected results, a monitor pops and
// compares on each output handshake and checks latency and result stability.
module tb_hansen_muldiv;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] MinVal = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        rand_rdy = 1'b0;
  logic        rdy_fix = 1'b1;
  logic        rnd_rdy = 1'b1;
  logic        out_ready;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [31:0] result;

  assign out_ready = rand_rdy ? rnd_rdy : rdy_fix;

  hansen_muldiv #(
    .XLEN(XLEN)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .kill_i     (kill),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .busy_o     (busy)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc_edge;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails = 0;
  int   edges = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  initial forever begin
    @(negedge clk);
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain wide arithmetic following the RISC-V M rules
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    logic [63:0] p;
    logic        ovf;
    ovf = (x == MinVal) && (y == 32'hffff_ffff);
    case (o)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'd1: begin p = longint'($signed(x)) * longint'($signed(y)); return p[63:32]; end
      3'd2: begin p = longint'($signed(x)) * longint'({32'b0, y}); return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hffff_ffff;
        if (ovf) return x;
        return $signed(x) / $signed(y);
      end
      3'd5: return (y == 0) ? 32'hffff_ffff : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        return $signed(x) % $signed(y);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Edges from the accept edge to the edge that raises out_valid
  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2]) begin
      if (y == 0) return 0;
      if ((o == 3'd4 || o == 3'd6) && x == MinVal && y == 32'hffff_ffff) return 0;
      return XLEN + 1;
    end
`ifdef HANSEN_MULDIV_FAST_MUL_EN
    return 0;
`else
    return XLEN + 1;
`endif
  endfunction

  // Monitor: samples mid-low-phase, after DUT outputs settle and before the next edge
  initial begin
    logic        pv = 1'b0;
    logic        ph = 1'b0;
    logic [31:0] pr = '0;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        pv = 1'b0;
        ph = 1'b0;
      end else begin
        if (out_valid && (!pv || ph)) begin
          if (q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_valid: got out_valid=1 result=%0h expected no output", result);
          end else begin
            check("latency", 64'(edges - q[0].acc_edge), 64'(q[0].lat));
          end
        end else if (out_valid && pv) begin
          check("hold_result", result, pr);
        end
        if (out_valid && out_ready && q.size() > 0) begin
          check("result", result, q[0].res);
          void'(q.pop_front());
        end
        pv = out_valid;
        ph = out_valid && out_ready;
        pr = result;
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input bit push);
    int   g = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) begin
      checks++;
      fails++;
      $display("FAIL issue_timeout: in_ready=%0b expected 1", in_ready);
      return;
    end
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    if (push) begin
      e.res = exp;
      e.lat = ref_lat(o, x, y);
      e.acc_edge = edges + 1;
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((q.size() != 0 || !in_ready) && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (g >= 400) begin
      checks++;
      fails++;
      $display("FAIL idle_timeout: pending=%0d in_ready=%0b expected 0 and 1", q.size(), in_ready);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hffff_ffff;
      2: return MinVal;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
  } vec_t;

  vec_t dir[$] = '{
    '{3'd0, 32'd7,        32'd6,        32'd42},
    '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    '{3'd3, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe},
    '{3'd2, 32'hffff_ffff, 32'd2,        32'hffff_ffff},
    '{3'd4, 32'hffff_fff9, 32'd2,        32'hffff_fffd},
    '{3'd6, 32'hffff_fff9, 32'd2,        32'hffff_ffff},
    '{3'd5, 32'd100,      32'd7,        32'd14},
    '{3'd7, 32'd100,      32'd7,        32'd2},
    '{3'd4, 32'd5,        32'd0,        32'hffff_ffff},
    '{3'd6, 32'd5,        32'd0,        32'd5},
    '{3'd4, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000},
    '{3'd6, 32'h8000_0000, 32'hffff_ffff, 32'h0}
  };

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    int          g;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    foreach (dir[i]) begin
      issue(dir[i].o, dir[i].x, dir[i].y, dir[i].r, 1'b1);
      wait_idle();
    end

    // Backpressure: result must hold and no new accept while DONE
    rdy_fix = 1'b0;
    issue(3'd5, 32'd1000, 32'd7, 32'd142, 1'b1);
    g = 0;
    while (!out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    rdy_fix = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_busy", busy, 0);
    check("bp_release_in_ready", in_ready, 1);

    // Kill mid-CALC: no result may ever appear
    issue(3'd5, 32'd1000, 32'd7, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    check("pre_kill_busy", busy, 1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", busy, 0);
    check("kill_valid", out_valid, 0);
    check("kill_in_ready", in_ready, 1);
    repeat (40) @(negedge clk);

    // kill together with in_valid in IDLE must not accept
    op = 3'd0;
    a = 32'd3;
    b = 32'd3;
    in_valid = 1'b1;
    kill = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    kill = 1'b0;
    check("kill_no_accept", busy, 0);

    issue(3'd0, 32'd3, 32'd3, 32'd9, 1'b1);
    wait_idle();

    // Kill in DONE drops the pending result
    rdy_fix = 1'b0;
    issue(3'd4, 32'd5, 32'd0, 32'hffff_ffff, 1'b1);
    check("done_valid", out_valid, 1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("done_kill_valid", out_valid, 0);
    check("done_kill_busy", busy, 0);
    if (q.size() > 0) void'(q.pop_front());
    rdy_fix = 1'b1;

    // Asynchronous reset mid-CALC
    issue(3'd4, 32'd12345, 32'd67, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("areset_busy", busy, 0);
    check("areset_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);

    // Randomized traffic with random consumer backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 48; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = pick();
      ry = pick();
      issue(ro, rx, ry, ref_res(ro, rx, ry), 1'b1);
    end
    wait_idle();
    rand_rdy = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
